// File: rtl/mopshub_8b10b_pkg.sv
// Shared constants for the MOPSHUB 8b/10b encoder: K-code bytes, comma symbols and RD encoding.
package mopshub_8b10b_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYM_W  = 10;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [BYTE_W-1:0] K28_0 = 8'h1C;
    localparam logic [BYTE_W-1:0] K28_1 = 8'h3C;
    localparam logic [BYTE_W-1:0] K28_2 = 8'h5C;
    localparam logic [BYTE_W-1:0] K28_3 = 8'h7C;
    localparam logic [BYTE_W-1:0] K28_4 = 8'h9C;
    localparam logic [BYTE_W-1:0] K28_5 = 8'hBC;
    localparam logic [BYTE_W-1:0] K28_6 = 8'hDC;
    localparam logic [BYTE_W-1:0] K28_7 = 8'hFC;
    localparam logic [BYTE_W-1:0] K23_7 = 8'hF7;
    localparam logic [BYTE_W-1:0] K27_7 = 8'hFB;
    localparam logic [BYTE_W-1:0] K29_7 = 8'hFD;
    localparam logic [BYTE_W-1:0] K30_7 = 8'hFE;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h305;

endpackage

// File: rtl/enc_8b10b_core_mopshub.sv
// Combinational 8b/10b symbol builder: byte + K flag + entry RD -> {abcdei,fghj}, exit RD, illegal-K flag.
module enc_8b10b_core_mopshub
    import mopshub_8b10b_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              ki_i,
    input  logic              rd_i,
    output logic [SYM_W-1:0]  symbol_c_o,
    output logic              rd_next_c_o,
    output logic              k_illegal_c_o
);

    // {RD- form, RD+ form} of the data 6b block
    function automatic logic [11:0] tab_5b6b(input logic [4:0] x);
        case (x)
            5'd0:    tab_5b6b = {6'b100111, 6'b011000};
            5'd1:    tab_5b6b = {6'b011101, 6'b100010};
            5'd2:    tab_5b6b = {6'b101101, 6'b010010};
            5'd3:    tab_5b6b = {6'b110001, 6'b110001};
            5'd4:    tab_5b6b = {6'b110101, 6'b001010};
            5'd5:    tab_5b6b = {6'b101001, 6'b101001};
            5'd6:    tab_5b6b = {6'b011001, 6'b011001};
            5'd7:    tab_5b6b = {6'b111000, 6'b000111};
            5'd8:    tab_5b6b = {6'b111001, 6'b000110};
            5'd9:    tab_5b6b = {6'b100101, 6'b100101};
            5'd10:   tab_5b6b = {6'b010101, 6'b010101};
            5'd11:   tab_5b6b = {6'b110100, 6'b110100};
            5'd12:   tab_5b6b = {6'b001101, 6'b001101};
            5'd13:   tab_5b6b = {6'b101100, 6'b101100};
            5'd14:   tab_5b6b = {6'b011100, 6'b011100};
            5'd15:   tab_5b6b = {6'b010111, 6'b101000};
            5'd16:   tab_5b6b = {6'b011011, 6'b100100};
            5'd17:   tab_5b6b = {6'b100011, 6'b100011};
            5'd18:   tab_5b6b = {6'b010011, 6'b010011};
            5'd19:   tab_5b6b = {6'b110010, 6'b110010};
            5'd20:   tab_5b6b = {6'b001011, 6'b001011};
            5'd21:   tab_5b6b = {6'b101010, 6'b101010};
            5'd22:   tab_5b6b = {6'b011010, 6'b011010};
            5'd23:   tab_5b6b = {6'b111010, 6'b000101};
            5'd24:   tab_5b6b = {6'b110011, 6'b001100};
            5'd25:   tab_5b6b = {6'b100110, 6'b100110};
            5'd26:   tab_5b6b = {6'b010110, 6'b010110};
            5'd27:   tab_5b6b = {6'b110110, 6'b001001};
            5'd28:   tab_5b6b = {6'b001110, 6'b001110};
            5'd29:   tab_5b6b = {6'b101110, 6'b010001};
            5'd30:   tab_5b6b = {6'b011110, 6'b100001};
            default: tab_5b6b = {6'b101011, 6'b010100};
        endcase
    endfunction

    // {RD6- form, RD6+ form} of the fghj block; K28 uses its own column
    function automatic logic [7:0] tab_3b4b(input logic [2:0] y, input logic k28);
        case ({k28, y})
            4'b0_000: tab_3b4b = {4'b1011, 4'b0100};
            4'b0_001: tab_3b4b = {4'b1001, 4'b1001};
            4'b0_010: tab_3b4b = {4'b0101, 4'b0101};
            4'b0_011: tab_3b4b = {4'b1100, 4'b0011};
            4'b0_100: tab_3b4b = {4'b1101, 4'b0010};
            4'b0_101: tab_3b4b = {4'b1010, 4'b1010};
            4'b0_110: tab_3b4b = {4'b0110, 4'b0110};
            4'b0_111: tab_3b4b = {4'b1110, 4'b0001};
            4'b1_000: tab_3b4b = {4'b1011, 4'b0100};
            4'b1_001: tab_3b4b = {4'b0110, 4'b1001};
            4'b1_010: tab_3b4b = {4'b1010, 4'b0101};
            4'b1_011: tab_3b4b = {4'b1100, 4'b0011};
            4'b1_100: tab_3b4b = {4'b1101, 4'b0010};
            4'b1_101: tab_3b4b = {4'b0101, 4'b1010};
            4'b1_110: tab_3b4b = {4'b1001, 4'b0110};
            default:  tab_3b4b = {4'b0111, 4'b1000};
        endcase
    endfunction

    logic [4:0]  x;
    logic [2:0]  y;
    logic        k28;
    logic        k_alt;
    logic [11:0] col6;
    logic [7:0]  col4;
    logic [5:0]  six;
    logic [3:0]  four;
    logic        rd6;
    logic        use_a7;

    always_comb begin
        x      = byte_i[4:0];
        y      = byte_i[7:5];
        k28    = ki_i && (x == K28_0[4:0]);
        k_alt  = ki_i && ((byte_i == K23_7) || (byte_i == K27_7) ||
                          (byte_i == K29_7) || (byte_i == K30_7));
        col6   = k28 ? {6'b001111, 6'b110000} : tab_5b6b(x);
        six    = rd_i ? col6[5:0] : col6[11:6];
        // Neutral 6b blocks have odd parity (three ones); the rest flip RD
        rd6    = rd_i ^ ~(^six);
        col4   = tab_3b4b(y, k28);
        four   = rd6 ? col4[3:0] : col4[7:4];
        use_a7 = rd6 ? (six[1:0] == 2'b00) : (six[1:0] == 2'b11);
        if (!k28 && (y == 3'd7) && (k_alt || use_a7)) begin
            four = rd6 ? 4'b1000 : 4'b0111;
        end
        symbol_c_o    = {six, four};
        rd_next_c_o   = rd6 ^ (^four);
        k_illegal_c_o = ki_i && !k28 && !k_alt;
    end

endmodule

// File: rtl/enc_8b10b_mopshub.sv
// Registered 8b/10b encoder for the MOPSHUB uplink; 1-cycle latency, tracks running disparity.
// Optional MOPSHUB_ENC_IDLE_COMMA_EN: idle cycles emit K28.5 at the current RD.
module enc_8b10b_mopshub
    import mopshub_8b10b_pkg::*;
#(
    parameter logic RST_RD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] datain,
    input  logic              ki,
    input  logic              datain_valid,
    output logic [SYM_W-1:0]  dataout,
    output logic              dataout_valid,
    output logic              rd_out,
    output logic              code_err
);

    logic [SYM_W-1:0] dataout_q, dataout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             rd_q, rd_d;
    logic [SYM_W-1:0] sym;
    logic             rd_nx;
    logic             k_ill;

    enc_8b10b_core_mopshub u_core (
        .byte_i        (datain),
        .ki_i          (ki),
        .rd_i          (rd_q),
        .symbol_c_o    (sym),
        .rd_next_c_o   (rd_nx),
        .k_illegal_c_o (k_ill)
    );

    always_comb begin
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        rd_d      = rd_q;
        if (datain_valid) begin
            dataout_d = sym;
            valid_d   = 1'b1;
            err_d     = k_ill;
            rd_d      = rd_nx;
        end
`ifdef MOPSHUB_ENC_IDLE_COMMA_EN
        else begin
            dataout_d = (rd_q == RD_POS) ? K28_5_RDP : K28_5_RDN;
            valid_d   = 1'b1;
            err_d     = 1'b0;
            rd_d      = ~rd_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= RST_RD;
        end else begin
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

    assign dataout       = dataout_q;
    assign dataout_valid = valid_q;
    assign rd_out        = rd_q;
    assign code_err      = err_q;

endmodule
